sar_a2d_dual: RTL



---
 rtl/sar_a2d_dual.sv | 80 ++++++++
 1 files changed

// File: rtl/sar_a2d_dual.sv
// sar_a2d_dual: dual-channel 12-bit SAR A2D controller with shared sample/settle timing
module sar_a2d_dual #(
  parameter int SMPL_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic        gt_sin,
  input  logic        gt_cos,
  output logic        smpl,
  output logic [11:0] sinSAR,
  output logic [11:0] cosSAR,
  output logic        cnv_cmplt,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;
  state_t state;
  logic [1:0] sin_sync, cos_sync;
  logic [7:0] smpl_cnt;
  logic [3:0] settle_cnt, bit_idx;
  logic [11:0] bit_mask, next_mask;
  logic last_smpl, last_settle;
  assign bit_mask    = 12'd1 << bit_idx;
  assign next_mask   = bit_mask >> 1;
  assign last_smpl   = smpl_cnt == 8'(SMPL_CYCLES - 1);
  assign last_settle = settle_cnt == 4'(SETTLE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sin_sync   <= 2'b00;
      cos_sync   <= 2'b00;
      smpl_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
      bit_idx    <= 4'd0;
      smpl       <= 1'b0;
      sinSAR     <= 12'h000;
      cosSAR     <= 12'h000;
      cnv_cmplt  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sin_sync  <= {sin_sync[0], gt_sin};
      cos_sync  <= {cos_sync[0], gt_cos};
      cnv_cmplt <= 1'b0;
      case (state)
        IDLE: if (strt_cnv) begin
          state    <= SAMPLE;
          smpl     <= 1'b1;
          busy     <= 1'b1;
          smpl_cnt <= 8'd0;
        end
        SAMPLE: if (last_smpl) begin
          state      <= CONVERT;
          smpl       <= 1'b0;
          sinSAR     <= 12'h800;
          cosSAR     <= 12'h800;
          bit_idx    <= 4'd11;
          settle_cnt <= 4'd0;
        end else begin
          smpl_cnt <= smpl_cnt + 8'd1;
        end
        CONVERT: if (last_settle) begin
          settle_cnt <= 4'd0;
          sinSAR     <= (sin_sync[1] ? sinSAR : sinSAR & ~bit_mask) | next_mask;
          cosSAR     <= (cos_sync[1] ? cosSAR : cosSAR & ~bit_mask) | next_mask;
          if (bit_idx == 4'd0) begin
            state     <= IDLE;
            cnv_cmplt <= 1'b1;
            busy      <= 1'b0;
          end else begin
            bit_idx <= bit_idx - 4'd1;
          end
        end else begin
          settle_cnt <= settle_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
